serial_packet_tx: RTL and testbench

Transmit-side framer for the UART link. Accepts a 32-bit result word through a valid/ready handshake and sends it to the host as a framed 8N1 byte packet. It contains its own bit-level serializer and baud counter, so the host can decode particle-filter outputs as multi-byte packets rather than raw single bytes. It sits between the filter datapath and the `ser_tx` pin in the top level.

---
 rtl/serial_packet_tx_if.sv | 14 +
 rtl/serial_packet_tx.sv | 149 ++++++++++++++
 tb/tb_serial_packet_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_packet_tx_if.sv
// serial_packet_tx_if
// Word-offer handshake between the filter datapath and the packet framer.
//   i_Data_Valid : producer offers i_Data_Word this cycle
//   i_Data_Word  : 32-bit result word
//   o_Ready      : framer can take a word (idle, or in its one-cycle DONE)
// Modports: master = word producer, slave = serial_packet_tx.
interface serial_packet_tx_if;
  logic        i_Data_Valid;
  logic [31:0] i_Data_Word;
  logic        o_Ready;

  modport master (output i_Data_Valid, output i_Data_Word, input o_Ready);
  modport slave  (input i_Data_Valid, input i_Data_Word, output o_Ready);
endinterface

// File: rtl/serial_packet_tx.sv
// serial_packet_tx
// Frames a 32-bit word as an 8N1 UART byte packet:
//   SYNC_BYTE, word[31:24], word[23:16], word[15:8], word[7:0] [, checksum]
// Optional feature macro: SERIAL_PKT_CHECKSUM_EN appends the XOR of the four
// data bytes as a sixth byte. Without it the packet is five bytes.
// Ports:
//   i_Clock, i_Reset : clock (rising edge), async active-high reset
//   bus (slave)      : i_Data_Valid / i_Data_Word in, o_Ready out
//   o_Tx_Serial      : UART line, idles high
//   o_Tx_Active      : high from acceptance until the last stop bit ends
//   o_Pkt_Done       : one-cycle pulse in the DONE cycle after the packet
module serial_packet_tx #(
  parameter int         CLOCK_FREQUENCY = 48000000,
  parameter int         BAUDRATE        = 115200,
  parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  serial_packet_tx_if.slave    bus,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Pkt_Done
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUDRATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef SERIAL_PKT_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic [31:0]      word;
  logic [7:0]       cur_byte;
  logic             bit_tick;
  logic             accept;
`ifdef SERIAL_PKT_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign bit_tick = (baud_cnt == CNT_LAST);
  assign accept   = bus.i_Data_Valid && bus.o_Ready;

  // Byte currently on the line, selected from the latched word.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx)
      3'd1:    cur_byte = word[31:24];
      3'd2:    cur_byte = word[23:16];
      3'd3:    cur_byte = word[15:8];
      3'd4:    cur_byte = word[7:0];
`ifdef SERIAL_PKT_CHECKSUM_EN
      3'd5:    cur_byte = csum;
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      word        <= '0;
`ifdef SERIAL_PKT_CHECKSUM_EN
      csum        <= '0;
`endif
      o_Tx_Serial <= 1'b1;
      bus.o_Ready <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Pkt_Done  <= 1'b0;
    end else begin
      o_Pkt_Done <= 1'b0;
      case (state)
        // DONE behaves like IDLE for acceptance so back-to-back words only
        // cost the single DONE cycle of idle-high line.
        S_IDLE, S_DONE: begin
          if (accept) begin
            word        <= bus.i_Data_Word;
`ifdef SERIAL_PKT_CHECKSUM_EN
            csum        <= bus.i_Data_Word[31:24] ^ bus.i_Data_Word[23:16] ^
                           bus.i_Data_Word[15:8]  ^ bus.i_Data_Word[7:0];
`endif
            o_Tx_Serial <= 1'b0;          // start bit of the sync byte
            bus.o_Ready <= 1'b0;
            o_Tx_Active <= 1'b1;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            state       <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end
        S_START: begin
          if (bit_tick) begin
            baud_cnt    <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= cur_byte[0];
            state       <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_Tx_Serial <= 1'b1;        // stop bit
              state       <= S_STOP;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_Tx_Serial <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              o_Pkt_Done  <= 1'b1;
              bus.o_Ready <= 1'b1;
              o_Tx_Active <= 1'b0;
              state       <= S_DONE;
            end else begin
              byte_idx    <= byte_idx + 3'd1;
              o_Tx_Serial <= 1'b0;        // next start bit, no gap
              state       <= S_START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_packet_tx.sv
module tb_serial_packet_tx;
  localparam int CF  = 1000;
  localparam int BR  = 100;
  localparam int CPB = CF / BR;
`ifdef SERIAL_PKT_CHECKSUM_EN
  localparam int NB      = 6;
  localparam int EXP_LAT = 601;
`else
  localparam int NB      = 5;
  localparam int EXP_LAT = 501;
`endif
  localparam logic [3:0] IDLE_E = 4'b1010;   // {line, active, ready, done}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, active, done;

  serial_packet_tx_if bus();

  serial_packet_tx #(.CLOCK_FREQUENCY(CF), .BAUDRATE(BR), .SYNC_BYTE(8'hA5)) dut (
    .i_Clock(clk), .i_Reset(rst), .bus(bus),
    .o_Tx_Serial(tx), .o_Tx_Active(active), .o_Pkt_Done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: on acceptance, expand the packet into its full per-cycle waveform.
  logic [3:0] mq[$];
  logic [3:0] cur = IDLE_E;
  logic [7:0] pb[6];
  logic       v;
  int         m_cyc = 0;
  int         acc_cyc = 0;
  int         done_cnt = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        cur = IDLE_E;
      end else begin
        if (bus.i_Data_Valid && cur[1]) begin
          pb[0] = 8'hA5;
          pb[1] = bus.i_Data_Word[31:24];
          pb[2] = bus.i_Data_Word[23:16];
          pb[3] = bus.i_Data_Word[15:8];
          pb[4] = bus.i_Data_Word[7:0];
          pb[5] = pb[1] ^ pb[2] ^ pb[3] ^ pb[4];
          for (int k = 0; k < NB; k++)
            for (int bi = 0; bi < 10; bi++) begin
              if (bi == 0)      v = 1'b0;
              else if (bi == 9) v = 1'b1;
              else              v = pb[k][bi-1];
              for (int r = 0; r < CPB; r++) mq.push_back({v, 3'b100});
            end
          mq.push_back(4'b1011);
          acc_cyc = m_cyc;
        end
        cur = (mq.size() > 0) ? mq.pop_front() : IDLE_E;
        m_cyc++;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        tests++;
        if ({tx, active, bus.o_Ready, done} !== cur) begin
          fails++;
          if (fails <= 20)
            $display("FAIL cycle_check cyc=%0d got line/act/rdy/done=%b expected %b",
                     m_cyc, {tx, active, bus.o_Ready, done}, cur);
        end
        if (done === 1'b1) done_cnt++;
      end
    end
  end

  // Line decoder: mid-bit sampling of 8N1 frames.
  logic [7:0] dq[$];
  logic [7:0] dec_b;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        tests++;
        if (tx !== 1'b0) begin fails++; $display("FAIL start_bit got %b expected 0", tx); end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          dec_b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL stop_bit got %b expected 1", tx); end
        dq.push_back(dec_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic offer(input logic [31:0] w);
    bus.i_Data_Word  = w;
    bus.i_Data_Valid = 1'b1;
    @(negedge clk);
    bus.i_Data_Valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s no o_Pkt_Done within 3000 cycles", nm);
    end
  endtask

  task automatic check_pkt(input string nm, input logic [7:0] e[6]);
    logic [7:0] got;
    chk({nm, "_len"}, dq.size(), NB);
    for (int k = 0; k < NB; k++) begin
      got = (k < dq.size()) ? dq[k] : 8'hxx;
      tests++;
      if (got !== e[k]) begin
        fails++;
        $display("FAIL %s byte%0d got %h expected %h", nm, k, got, e[k]);
      end
    end
    dq.delete();
  endtask

  logic [7:0] ev[6];

  initial begin
    bus.i_Data_Valid = 1'b0;
    bus.i_Data_Word  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (50) @(negedge clk);
    chk("idle_line", tx, 1);
    chk("idle_ready", bus.o_Ready, 1);
    chk("idle_active", active, 0);
    chk("idle_no_done", done_cnt, 0);

    // Single packet
    offer(32'h12345678);
    wait_done("pkt1");
    chk("lat1", m_cyc - acc_cyc, EXP_LAT);
    ev = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    check_pkt("pkt1", ev);
    chk("done_cnt1", done_cnt, 1);
    repeat (5) @(negedge clk);

    // Valid held, data changed mid-packet, second word taken in DONE
    bus.i_Data_Word  = 32'hDEADBEEF;
    bus.i_Data_Valid = 1'b1;
    repeat (200) @(negedge clk);
    bus.i_Data_Word  = 32'h0;
    wait_done("pkt2");
    ev = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    check_pkt("pkt2", ev);
    chk("done_line_high", tx, 1);
    @(negedge clk);
    chk("gap_start_bit", tx, 0);
    chk("gap_ready_low", bus.o_Ready, 0);
    bus.i_Data_Valid = 1'b0;
    wait_done("pkt3");
    chk("lat3", m_cyc - acc_cyc, EXP_LAT);
    ev = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_pkt("pkt3_zero", ev);
    repeat (5) @(negedge clk);

    // Reset during the third byte
    offer(32'hCAFEF00D);
    repeat (250) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_line", tx, 1);
    chk("rst_ready", bus.o_Ready, 1);
    chk("rst_active", active, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    dq.delete();
    offer(32'hA1B2C3D4);
    wait_done("pkt4");
    chk("lat4", m_cyc - acc_cyc, EXP_LAT);
    ev = '{8'hA5, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04};
    check_pkt("pkt4", ev);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
